// File: rtl/time_disp_pkg.sv
// Shared constants, FSM state type and 7-segment patterns for the time display multiplexer.
package time_disp_pkg;

  localparam int NUM_DIGITS  = 12;
  localparam int NUM_FIELDS  = 6;
  localparam int FIELD_W     = 7;
  localparam int CONV_CYCLES = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-high patterns, bit 0 = segment a .. bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [FIELD_W-1:0] clamp99(input logic [FIELD_W-1:0] v);
    clamp99 = (v > 7'd99) ? 7'd99 : v;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Iterative 7-bit double-dabble: start performs the first step, done flags the cycle whose
// edge completes the seventh step, and tens/ones carry that final result combinationally.
module bin2bcd_serial
  import time_disp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FIELD_W-1:0] bin,
  output logic               done,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  logic [7:0]         bcd;
  logic [FIELD_W-1:0] sr;
  logic [2:0]         cnt;
  logic [7:0]         adj;
  logic [7:0]         step;

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj  = {add3(bcd[7:4]), add3(bcd[3:0])};
    step = (adj << 1) | {7'b0, sr[FIELD_W-1]};
  end

  assign done = (cnt == 3'(CONV_CYCLES - 1));
  assign tens = step[7:4];
  assign ones = step[3:0];

  // cnt: 0 = never started, 1..6 = steps taken, 7 = finished and holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd <= '0;
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      bcd <= {7'b0, bin[FIELD_W-1]};
      sr  <= {bin[FIELD_W-2:0], 1'b0};
      cnt <= 3'd1;
    end else if (cnt != 3'd0 && cnt != 3'(CONV_CYCLES)) begin
      bcd <= step;
      sr  <= sr << 1;
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/time_display_mux.sv
// Snapshots six time fields, converts them serially to BCD and scans a 12-digit 7-segment display.
// Optional macro ONE_BASED_EN: day and month are shown 1-based (incremented before clamping).
module time_display_mux
  import time_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            second,
  input  logic [5:0]            minute,
  input  logic [4:0]            hour,
  input  logic [4:0]            day,
  input  logic [3:0]            month,
  input  logic [6:0]            year,
  input  logic                  load,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  state_t             state;
  logic [2:0]         field;
  logic               kick;
  logic [FIELD_W-1:0] fld_in [NUM_FIELDS];
  logic [FIELD_W-1:0] snap   [NUM_FIELDS];
  logic [7:0]         shadow [NUM_FIELDS];
  logic [3:0]         disp   [NUM_DIGITS];
  logic               conv_done;
  logic [3:0]         conv_tens;
  logic [3:0]         conv_ones;

  always_comb begin
    fld_in[0] = clamp99(7'(second));
    fld_in[1] = clamp99(7'(minute));
    fld_in[2] = clamp99(7'(hour));
`ifdef ONE_BASED_EN
    fld_in[3] = clamp99(7'(day) + 7'd1);
    fld_in[4] = clamp99(7'(month) + 7'd1);
`else
    fld_in[3] = clamp99(7'(day));
    fld_in[4] = clamp99(7'(month));
`endif
    fld_in[5] = clamp99(year);
  end

  bin2bcd_serial u_conv (
    .clk   (clk),
    .reset (reset),
    .start (kick),
    .bin   (snap[field]),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // kick starts the converter for the current field; the next field is kicked on the
  // same edge that captures the previous result, so fields run back to back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      field  <= '0;
      kick   <= 1'b0;
      busy   <= 1'b0;
      snap   <= '{default: '0};
      shadow <= '{default: '0};
      disp   <= '{default: '0};
    end else begin
      kick <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            snap  <= fld_in;
            field <= '0;
            kick  <= 1'b1;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          if (conv_done) begin
            shadow[field] <= {conv_tens, conv_ones};
            if (field == 3'(NUM_FIELDS - 1)) begin
              state <= COMMIT;
            end else begin
              field <= field + 3'd1;
              kick  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          for (int k = 0; k < NUM_FIELDS; k++) begin
            disp[2*k]   <= shadow[k][3:0];
            disp[2*k+1] <= shadow[k][7:4];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [15:0] presc;
  logic [3:0]  idx;
  logic [3:0]  idx_nxt;
  logic [3:0]  nib_nxt;
  logic [6:0]  seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  // The digit shown next is looked up in the buffer as it will be after this edge,
  // so freshly committed digits appear on the cycle right after the commit.
  always_comb begin
    idx_nxt = idx;
    if (presc == 16'(REFRESH_DIV - 1)) begin
      idx_nxt = (idx == 4'(NUM_DIGITS - 1)) ? 4'd0 : idx + 4'd1;
    end
    if (state == COMMIT) begin
      nib_nxt = idx_nxt[0] ? shadow[idx_nxt[3:1]][7:4] : shadow[idx_nxt[3:1]][3:0];
    end else begin
      nib_nxt = disp[idx_nxt];
    end
    seg_nxt = seg_decode(nib_nxt);
    sel_nxt = NUM_DIGITS'(1) << idx_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      idx       <= '0;
      seg       <= SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
      digit_sel <= SEG_ACTIVE_LOW ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
    end else begin
      presc     <= (presc == 16'(REFRESH_DIV - 1)) ? 16'd0 : presc + 16'd1;
      idx       <= idx_nxt;
      seg       <= SEG_ACTIVE_LOW ? ~seg_nxt : seg_nxt;
      digit_sel <= SEG_ACTIVE_LOW ? ~sel_nxt : sel_nxt;
    end
  end

endmodule

// File: tb/tb_time_display_mux.sv
// Directed and randomized checks of time_display_mux against an arithmetic reference model.
module tb_time_display_mux;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  second = '0;
  logic [5:0]  minute = '0;
  logic [4:0]  hour = '0;
  logic [4:0]  day = '0;
  logic [3:0]  month = '0;
  logic [6:0]  year = '0;
  logic        load = 1'b0;
  logic        busy;
  logic [6:0]  seg;
  logic [11:0] digit_sel;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [47:0] exp_q[$];
  logic [47:0] shown = '0;

  time_display_mux #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .second    (second),
    .minute    (minute),
    .hour      (hour),
    .day       (day),
    .month     (month),
    .year      (year),
    .load      (load),
    .busy      (busy),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  // rising edges since reset release; drives the scanner reference
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [6:0] pattern(input int d);
    case (d)
      0: pattern = 7'h3F;
      1: pattern = 7'h06;
      2: pattern = 7'h5B;
      3: pattern = 7'h4F;
      4: pattern = 7'h66;
      5: pattern = 7'h6D;
      6: pattern = 7'h7D;
      7: pattern = 7'h07;
      8: pattern = 7'h7F;
      9: pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
  endfunction

  // Expected 12 digits, nibble i = display index i (ones then tens of each field).
  function automatic logic [47:0] model(input int s, m, h, d, mo, y);
    int v[6];
    int c;
    logic [47:0] r;
    v = '{s, m, h, d, mo, y};
`ifdef ONE_BASED_EN
    v[3] = v[3] + 1;
    v[4] = v[4] + 1;
`endif
    r = '0;
    for (int k = 0; k < 6; k++) begin
      c = (v[k] > 99) ? 99 : v[k];
      r[k*8 +: 4]     = 4'(c % 10);
      r[k*8 + 4 +: 4] = 4'(c / 10);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input int s, m, h, d, mo, y);
    second = 6'(s);
    minute = 6'(m);
    hour   = 5'(h);
    day    = 5'(d);
    month  = 4'(mo);
    year   = 7'(y);
  endtask

  task automatic start_conv(input int s, m, h, d, mo, y);
    set_in(s, m, h, d, mo, y);
    exp_q.push_back(model(s, m, h, d, mo, y));
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_commit(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check(tag, 64'(n), 64'(exp_cycles));
    if (exp_q.size() != 0) shown = exp_q.pop_front();
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(1'b0));
    check({tag, "_sel"}, 64'(digit_sel), 64'(12'hFFE));
    check({tag, "_seg"}, 64'(seg), 64'(7'h40));
  endtask

  task automatic scan(input string tag, input int n);
    int idx;
    logic [11:0] es;
    logic [6:0]  eg;
    repeat (n) begin
      idx = (cyc / DIV) % 12;
      es  = ~(12'b1 << idx);
      eg  = ~pattern(int'(shown[idx*4 +: 4]));
      check({tag, "_sel"}, 64'(digit_sel), 64'(es));
      check({tag, "_seg"}, 64'(seg), 64'(eg));
      tick();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    reset = 1'b0;
    scan("rst_scan", 8);

    // all fields at their nominal maximum
    start_conv(59, 59, 23, 29, 11, 99);
    check("full_busy_e0", 64'(busy), 64'(1'b1));
    wait_commit("full_latency", 43);
    scan("full", 52);

    // clamp of out-of-range values
    start_conv(63, 7, 0, 0, 0, 120);
    wait_commit("clamp_latency", 43);
    scan("clamp", 48);

    // loads at cycles 10 and 43 are dropped, held load at 44 is accepted
    start_conv(12, 34, 5, 6, 7, 8);
    set_in(1, 2, 3, 4, 5, 6);
    repeat (9) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    check("coll_busy10", 64'(busy), 64'(1'b1));
    repeat (32) tick();
    set_in(45, 17, 9, 21, 3, 77);
    load = 1'b1;
    tick();
    check("coll_drop43", 64'(busy), 64'(1'b0));
    shown = exp_q.pop_front();
    exp_q.push_back(model(45, 17, 9, 21, 3, 77));
    tick();
    load = 1'b0;
    check("coll_accept44", 64'(busy), 64'(1'b1));
    scan("coll_hold", 40);
    wait_commit("coll_tail", 3);
    scan("coll_new", 48);

    // reset 20 cycles into a conversion
    start_conv(33, 44, 11, 22, 9, 55);
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check_idle_reset("reset_mid");
    void'(exp_q.pop_front());
    shown = '0;
    @(negedge clk);
    reset = 1'b0;
    scan("rst_mid_scan", 48);

    // randomized full-width inputs
    repeat (4) begin
      start_conv(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 127)));
      wait_commit("rand_latency", 43);
      scan("rand", 48);
    end

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_display_mux.md
Name: time_display_mux

Overview:
- Sits directly downstream of the calendar/clock counter chain and drives a 12-digit multiplexed 7-segment display.
- On a load strobe it snapshots the six binary time fields (second, minute, hour, day, month, year).
- Each field is converted serially to two BCD digits, and all digits commit atomically to a display buffer.
- A free-running refresh scanner strobes one digit at a time.

Parameters:
- REFRESH_DIV, 1000: clk cycles each digit stays selected; legal range 2..65535.
- SEG_ACTIVE_LOW, 1: 1 = seg and digit_sel are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- second  in  6  binary seconds, 0..59 nominal
- minute  in  6  binary minutes, 0..59 nominal
- hour  in  5  binary hours, 0..23 nominal
- day  in  5  binary day, 0..29 nominal
- month  in  4  binary month, 0..11 nominal
- year  in  7  binary year, 0..99 nominal
- load  in  1  single-cycle request to snapshot and convert the inputs
- busy  out  1  conversion in progress; load is ignored while high
- seg  out  7  segment drive; seg[0]=a .. seg[6]=g
- digit_sel  out  12  one-hot digit enable (inverted when SEG_ACTIVE_LOW=1)

Behaviour:
- Reset (asynchronous) clears the following:
  - snapshot, BCD buffer and FSM (-> IDLE), busy=0
  - refresh prescaler=0, digit index=0
  - outputs: digit_sel selects digit 0; seg shows '0' (active-high 7'b0111111, active-low 7'b1000000)
- Digit map:
  - index 2k = ones digit, 2k+1 = tens digit of field k
  - field order k = 0..5: second, minute, hour, day, month, year
- Clamp: any field value >99 is clamped to 99 at snapshot. Values 60..99 are displayed unmodified (no range check).
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: load=1 at edge E0 captures the clamped inputs -> CONV, busy=1 after E0.
  - CONV: field k is shifted through the double-dabble (add-3 if nibble >=5, then shift) over exactly 7 cycles. Fields run back to back, k=0..5, on edges E1..E42. Each field's result goes to a shadow register.
  - COMMIT: edge E43 copies the shadow into the display buffer in one cycle -> IDLE, busy=0 after E43.
  - New digits are visible on seg from the cycle after E43.
- Latency: 43 cycles, load to commit; throughput is one conversion per 44 cycles.
- load while busy=1 (including the COMMIT cycle) is dropped, not queued.
- load held high is re-accepted on the first IDLE cycle.
- The display buffer never shows a partially converted value.
- Reset mid-conversion aborts it; the display reverts to all zeros.
- Scanner:
  - The prescaler counts 0..REFRESH_DIV-1 independently of the FSM.
  - At terminal count the digit index increments and wraps 11 -> 0.
  - digit_sel and seg are registered and change on the same edge, so there is no ghosting cycle.
- Decoder: BCD 0..9 use standard patterns; 10..15 are unreachable and blank all segments.

Optional Feature:
- Macro: ONE_BASED_EN.
- Defined: day and month are incremented by 1 at snapshot (before clamping), so day 0..29 displays 1..30 and month 0..11 displays 1..12. The other fields are unchanged.
- Undefined: all fields are displayed 0-based, exactly as received.
- Conversion latency is identical in both cases.

Decomposition:
- Shared package time_disp_pkg holds:
  - NUM_DIGITS=12, NUM_FIELDS=6, FIELD_W=7, CONV_CYCLES=7
  - FSM state typedef (IDLE/CONV/COMMIT)
  - 7-segment pattern constants for 0..9 and blank
- One sub-module: bin2bcd_serial.
  - 7-bit iterative double-dabble with start/done, producing two BCD nibbles.
  - Instantiated once and reused across the six fields.

Test Plan:
- Reset mid-operation: assert reset at cycle 20 after load -> busy=0 immediately; digit_sel = digit 0; seg='0'; buffer all zeros.
- Full conversion: inputs 59/59/23/29/11/99, pulse load -> busy high exactly 43 cycles; buffer digits index 0..11 = 9,5,9,5,3,2,9,2,1,1,9,9.
- Scanning: REFRESH_DIV=4 -> digit_sel rotates every 4 cycles through 12 one-hot values and wraps to digit 0 after 48 cycles; seg matches the buffered digit each slot.
- Load collision: second load pulses at cycles 10 and 43 after the first load -> both ignored; buffer holds the first snapshot; a third load at cycle 44 is accepted.
- Clamp: year=120, second=63 -> year digits 9,9; second digits 3,6.
- ONE_BASED_EN: day=29, month=11 -> day digits 0,3; month digits 2,1. Without the macro -> 9,2 and 1,1.
